// File: rtl/cnn_result_buffer.sv
// Result sink for the CNN accelerator: packs result words into bus-wide RAM words
// and exposes them, plus done/count/overflow status, on a bus read port.
module cnn_result_buffer #(
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_SIZE = 4096,
   localparam int NUM_WORDS = BUS_DATA_WIDTH / DATA_WIDTH,
   localparam int DIM_WIDTH = $clog2(MAX_SIZE) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      startIn,
   input  logic [DIM_WIDTH-1:0]      expCountIn,
   input  logic                      validIn,
   input  logic [DATA_WIDTH-1:0]     dataIn,
   output logic                      readyOut,
   input  logic                      rdEnIn,
   input  logic [BUS_ADDR_WIDTH-1:0] addrIn,
   output logic [BUS_DATA_WIDTH-1:0] rdDataOut,
   output logic                      rdValidOut,
   output logic                      doneOut,
   output logic [DIM_WIDTH-1:0]      countOut,
   output logic                      overflowOut
);

   localparam int DEPTH = MAX_SIZE / NUM_WORDS;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LANE_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int ADDR_SHIFT = $clog2(BUS_DATA_WIDTH / 8);
   localparam logic [DIM_WIDTH-1:0] MAX_SIZE_D = DIM_WIDTH'(MAX_SIZE);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} stateT;

   stateT state, nextState;

   logic [DIM_WIDTH-1:0]      expCount;
   logic [DIM_WIDTH-1:0]      countNext;
   logic [LANE_W-1:0]         lane;
   logic [BUS_DATA_WIDTH-1:0] packReg;
   logic [BUS_DATA_WIDTH-1:0] packedWord;
   logic [IDX_W-1:0]          wordIdx;
   logic                      goDone;
   logic                      accept;
   logic                      lastResult;
   logic                      flushWord;
   logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];
   logic [BUS_ADDR_WIDTH-1:0] rdIdx;
   logic                      rdInRange;

   // Handshake: a result transfers on a rising edge where validIn and readyOut are both high;
   // readyOut is registered and only high in COLLECT, and startIn discards a same-cycle transfer.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState  = state;
      goDone     = (expCountIn > MAX_SIZE_D) || (expCountIn == '0);
      countNext  = countOut + DIM_WIDTH'(1);
      lastResult = (countNext == expCount);
      accept     = validIn && readyOut && !startIn;
      flushWord  = accept && ((lane == LAST_LANE) || lastResult);
      if (startIn) begin
         nextState = goDone ? DONE : COLLECT;
      end else begin
         case (state)
            COLLECT: if (accept && lastResult) nextState = DONE;
            default: nextState = state;
         endcase
      end
   end

   // Lanes below the current one come from the pack register, lanes above stay zero.
   always_comb begin
      packedWord = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (LANE_W'(i) < lane)
            packedWord[i*DATA_WIDTH +: DATA_WIDTH] = packReg[i*DATA_WIDTH +: DATA_WIDTH];
         else if (LANE_W'(i) == lane)
            packedWord[i*DATA_WIDTH +: DATA_WIDTH] = dataIn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expCount    <= '0;
         countOut    <= '0;
         lane        <= '0;
         packReg     <= '0;
         wordIdx     <= '0;
         readyOut    <= 1'b0;
         doneOut     <= 1'b0;
         overflowOut <= 1'b0;
      end else if (startIn) begin
         expCount    <= expCountIn;
         countOut    <= '0;
         lane        <= '0;
         packReg     <= '0;
         wordIdx     <= '0;
         readyOut    <= !goDone;
         doneOut     <= goDone;
         overflowOut <= (expCountIn > MAX_SIZE_D);
      end else if (accept) begin
         countOut <= countNext;
         if (flushWord) begin
            lane    <= '0;
            packReg <= '0;
            wordIdx <= wordIdx + IDX_W'(1);
         end else begin
            lane    <= lane + LANE_W'(1);
            packReg <= packedWord;
         end
         if (lastResult) begin
            readyOut <= 1'b0;
            doneOut  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (flushWord) mem[wordIdx] <= packedWord;
   end

   assign rdIdx     = addrIn >> ADDR_SHIFT;
   assign rdInRange = (rdIdx < BUS_ADDR_WIDTH'(DEPTH));

   // Nonblocking RAM read gives old contents when the same word is written on this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdValidOut <= 1'b0;
         rdDataOut  <= '0;
      end else begin
         rdValidOut <= rdEnIn;
         if (rdEnIn) rdDataOut <= rdInRange ? mem[rdIdx[IDX_W-1:0]] : '0;
      end
   end

endmodule
